rom_matrix_streamer: RTL

Sequencer that reads a rectangular matrix out of a `block_rom` instance and presents it as a valid/ready element stream to the multiply datapath. It supports row-major or column-major traversal at one element per cycle under full backpressure. It drives the ROM's address port and samples its combinational data output. It sits between the operand ROMs and the matrix-multiply array loaders.

---
 rtl/matrix_pkg.sv | 24 ++
 rtl/mat_index_walker.sv | 86 ++++++++
 rtl/rom_matrix_streamer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types and parameter rules for the ROM matrix streaming blocks.
// Address and dimension widths are always derived from the ROM depth.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } stream_state_t;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a dimension can hold the full depth L.
    function automatic int dw_of(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/mat_index_walker.sv
// Fetch-side index walker: tracks (row, col) and the ROM address of the next
// element, stepping incrementally in row- or column-major order.
module mat_index_walker
    import matrix_pkg::*;
#(
    parameter  int L  = 32,
    localparam int AW = aw_of(L),
    localparam int DW = dw_of(L)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_i,
    input  logic          step_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [DW-1:0] n_rows_i,
    input  logic [DW-1:0] n_cols_i,
    input  logic          col_major_i,
    output logic [DW-1:0] fr_o,
    output logic [DW-1:0] fc_o,
    output logic [AW-1:0] faddr_o,
    output logic          last_o
);

    logic [DW-1:0] fr_q, fr_d;
    logic [DW-1:0] fc_q, fc_d;
    logic [AW-1:0] faddr_q, faddr_d;
    logic [AW-1:0] base_q, base_d;
    logic          row_end;
    logic          col_end;

    assign row_end = (fr_q == n_rows_i - DW'(1));
    assign col_end = (fc_q == n_cols_i - DW'(1));

    always_comb begin
        fr_d    = fr_q;
        fc_d    = fc_q;
        faddr_d = faddr_q;
        base_d  = base_q;
        if (init_i) begin
            fr_d    = '0;
            fc_d    = '0;
            faddr_d = base_addr_i;
            base_d  = base_addr_i;
        end else if (step_i) begin
            if (col_major_i) begin
                // Column wrap restarts from the top of the next column.
                if (row_end) begin
                    fr_d    = '0;
                    fc_d    = fc_q + DW'(1);
                    faddr_d = base_q + fc_q[AW-1:0] + AW'(1);
                end else begin
                    fr_d    = fr_q + DW'(1);
                    faddr_d = faddr_q + n_cols_i[AW-1:0];
                end
            end else begin
                if (col_end) begin
                    fc_d = '0;
                    fr_d = fr_q + DW'(1);
                end else begin
                    fc_d = fc_q + DW'(1);
                end
                faddr_d = faddr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fr_q    <= '0;
            fc_q    <= '0;
            faddr_q <= '0;
            base_q  <= '0;
        end else begin
            fr_q    <= fr_d;
            fc_q    <= fc_d;
            faddr_q <= faddr_d;
            base_q  <= base_d;
        end
    end

    assign fr_o    = fr_q;
    assign fc_o    = fc_q;
    assign faddr_o = faddr_q;
    assign last_o  = row_end && col_end;

endmodule

// File: rtl/rom_matrix_streamer.sv
// Streams a rectangular matrix from an external block_rom as a valid/ready
// element stream, with row- or column-major traversal and abort support.
module rom_matrix_streamer
    import matrix_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int L  = 32,
    localparam int AW = aw_of(L),
    localparam int DW = dw_of(L)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [DW-1:0] n_rows,
    input  logic [DW-1:0] n_cols,
    input  logic          col_major,
    output logic [AW-1:0] rom_addr,
    input  logic [W-1:0]  rom_data,
    output logic [W-1:0]  out_data,
    output logic [DW-1:0] out_row,
    output logic [DW-1:0] out_col,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    if (!is_pow2(L)) begin : g_bad_depth
        $error("rom_matrix_streamer: L must be a power of two");
    end

    stream_state_t state_q, state_d;

    logic [DW-1:0] rows_q, rows_d;
    logic [DW-1:0] cols_q, cols_d;
    logic          cm_q, cm_d;
    logic [W-1:0]  data_q, data_d;
    logic [DW-1:0] row_q, row_d;
    logic [DW-1:0] col_q, col_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;
    logic          pending_q, pending_d;

    logic          walk_init;
    logic          walk_step;
    logic [DW-1:0] fr;
    logic [DW-1:0] fc;
    logic [AW-1:0] faddr;
    logic          walk_last;
    logic          hs;

    mat_index_walker #(
        .L(L)
    ) u_walker (
        .clk         (clk),
        .rst         (rst),
        .init_i      (walk_init),
        .step_i      (walk_step),
        .base_addr_i (base_addr),
        .n_rows_i    (rows_q),
        .n_cols_i    (cols_q),
        .col_major_i (cm_q),
        .fr_o        (fr),
        .fc_o        (fc),
        .faddr_o     (faddr),
        .last_o      (walk_last)
    );

    assign hs = valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        cm_d      = cm_q;
        data_d    = data_q;
        row_d     = row_q;
        col_d     = col_q;
        last_d    = last_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        walk_init = 1'b0;
        walk_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d = n_rows;
                    cols_d = n_cols;
                    cm_d   = col_major;
                    if ((n_rows != '0) && (n_cols != '0)) begin
                        state_d   = STREAM;
                        walk_init = 1'b1;
                        pending_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            STREAM: begin
                if (abort) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                    pending_d = 1'b0;
                end else begin
                    // Walker stays on the final index so rom_addr holds it afterwards.
                    if ((!valid_q || out_ready) && pending_q) begin
                        data_d    = rom_data;
                        row_d     = fr;
                        col_d     = fc;
                        last_d    = walk_last;
                        valid_d   = 1'b1;
                        walk_step = !walk_last;
                        pending_d = !walk_last;
                    end else if (hs) begin
                        valid_d = 1'b0;
                    end
                    if (hs && last_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            cm_q      <= 1'b0;
            data_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            cm_q      <= cm_d;
            data_q    <= data_d;
            row_q     <= row_d;
            col_q     <= col_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

    assign rom_addr  = faddr;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == STREAM);
    assign done      = (state_q == DONE);

endmodule
